fixed_point_div_sequencer: RTL

FIXED_POINT_DIV_SEQUENCER -- requirements
Module: fixed_point_div_sequencer

---
 rtl/fixed_point_div_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fixed_point_div_sequencer.sv
// rtl/fixed_point_div_sequencer.sv - operand/handshake sequencer around an iterative fixed-point divider
//
// Accepts a dividend/divisor pair, pulses the divider load and start strobes,
// waits ITER iteration cycles, captures quotient/overflow and holds them until
// the consumer takes the result.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b  operand pair input handshake
//   dv_ld_a/dv_ld_b/dv_start  one-cycle strobes to the divider
//   dv_a/dv_b                 operands driven to the divider
//   dv_q/dv_ov                divider quotient and overflow flag
//   out_valid/out_ready       result handshake
//   out_q/out_ov/out_dz       captured quotient, overflow, divide-by-zero flag
//   busy                      high whenever the sequencer is not idle
//
// Optional feature: define DIV_ZERO_BYPASS_EN to short-circuit a zero divisor
// straight to the result state with a saturated quotient.
module fixed_point_div_sequencer #(
  parameter int ITER = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_a,
  input  logic [9:0] in_b,
  output logic       dv_ld_a,
  output logic       dv_ld_b,
  output logic       dv_start,
  output logic [9:0] dv_a,
  output logic [9:0] dv_b,
  input  logic [9:0] dv_q,
  input  logic       dv_ov,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_q,
  output logic       out_ov,
  output logic       out_dz,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [9:0] r_a;
  logic [9:0] r_b;
  logic [9:0] r_q;
  logic       r_ov;
  logic       r_ld;
  logic       r_start;
  logic       r_out_valid;
  logic       r_busy;
  logic       r_in_ready;
`ifdef DIV_ZERO_BYPASS_EN
  logic       r_dz;
`endif

  // All outputs come straight from registers that are updated together with
  // the state, so each strobe lines up exactly with its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_a         <= 10'd0;
      r_b         <= 10'd0;
      r_q         <= 10'd0;
      r_ov        <= 1'b0;
      r_ld        <= 1'b0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      r_dz        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            if (in_b == 10'd0) begin
              // Zero divisor: the divider is never touched.
              r_state     <= DONE;
              r_q         <= 10'h3FF;
              r_ov        <= 1'b1;
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_ld    <= 1'b1;
            end
`else
            r_state <= LOAD;
            r_ld    <= 1'b1;
`endif
          end else begin
            // Also raises in_ready on the first cycle out of reset.
            r_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          r_ld    <= 1'b0;
          r_start <= 1'b1;
          r_state <= START;
        end
        START: begin
          r_start <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST) begin
            r_q         <= dv_q;
            r_ov        <= dv_ov;
`ifdef DIV_ZERO_BYPASS_EN
            r_dz        <= 1'b0;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign dv_ld_a   = r_ld;
  assign dv_ld_b   = r_ld;
  assign dv_start  = r_start;
  assign dv_a      = r_a;
  assign dv_b      = r_b;
  assign out_valid = r_out_valid;
  assign out_q     = r_q;
  assign out_ov    = r_ov;
  assign busy      = r_busy;
`ifdef DIV_ZERO_BYPASS_EN
  assign out_dz    = r_dz;
`else
  assign out_dz    = 1'b0;
`endif

endmodule
